// File: rtl/controlador_rpn_if.sv
// Board-side bundle of the RPN sequencing controller.
// slave  : controller side (raw buttons/selector/error in, command pulses and status out)
// master : board/stack side (drives buttons, selector and erro_ula; observes the controller)
interface controlador_rpn_if;
    logic       btn_numero;
    logic       btn_executar;
    logic       btn_limpar;
    logic [2:0] chave_operacao;
    logic       erro_ula;
    logic       entrada_numero;
    logic       executar;
    logic       limpar_pilha;
    logic [2:0] operacao_out;
    logic [1:0] n_elem;
    logic [2:0] estado;
    logic       ocupado;
    logic       rejeitado;

    modport slave (
        input  btn_numero, btn_executar, btn_limpar, chave_operacao, erro_ula,
        output entrada_numero, executar, limpar_pilha, operacao_out,
        output n_elem, estado, ocupado, rejeitado
    );

    modport master (
        output btn_numero, btn_executar, btn_limpar, chave_operacao, erro_ula,
        input  entrada_numero, executar, limpar_pilha, operacao_out,
        input  n_elem, estado, ocupado, rejeitado
    );
endinterface

// File: rtl/controlador_rpn.sv
// Sequencing controller for the 2-level RPN stack/ULA datapath.
// Ports: clk, rst (async, active-low), bus (controlador_rpn_if.slave):
//   buttons/selector/erro_ula in; entrada_numero/executar/limpar_pilha pulses,
//   operacao_out, n_elem, estado, ocupado, rejeitado out (all registered).
module controlador_rpn #(
    parameter int unsigned ULA_LATENCIA = 1
) (
    input  logic              clk,
    input  logic              rst,
    controlador_rpn_if.slave  bus
);
    localparam int unsigned CNT_W = 3;
    localparam int unsigned BTN_W = 3;   // bit 0 numero, bit 1 executar, bit 2 limpar

    localparam logic [2:0] S_VAZIO     = 3'd0;
    localparam logic [2:0] S_UM        = 3'd1;
    localparam logic [2:0] S_DOIS      = 3'd2;
    localparam logic [2:0] S_ESPERA    = 3'd3;
    localparam logic [2:0] S_EXEC      = 3'd4;
    localparam logic [2:0] S_CHECA     = 3'd5;
    localparam logic [2:0] S_RESULTADO = 3'd6;
    localparam logic [2:0] S_ERRO      = 3'd7;

    logic [BTN_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
    logic [BTN_W-1:0] press_q, press_d;
    logic [1:0]       fill_q, fill_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             push_q, push_d, exec_q, exec_d, clr_q, clr_d, rej_q, rej_d;
    logic [1:0]       n_elem_q, n_elem_d;
    logic             ocupado_q, ocupado_d;
    logic             p_numero, p_executar, p_limpar;

    // Synchronizer + edge detector. fill_q blocks edges until the pipeline holds
    // only post-reset samples, so a button held through reset gives no press.
    always_comb begin
        sync1_d = {bus.btn_limpar, bus.btn_executar, bus.btn_numero};
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
        press_d = (fill_q == 2'd3) ? (sync2_q & ~hist_q) : BTN_W'(0);
    end

    assign p_numero   = press_q[0];
    assign p_executar = press_q[1];
    assign p_limpar   = press_q[2];

    // Next state and registered command outputs; priority limpar > executar > numero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        push_d  = 1'b0;
        exec_d  = 1'b0;
        clr_d   = 1'b0;
        rej_d   = 1'b0;

        if (p_limpar) begin
            clr_d   = 1'b1;
            op_d    = 3'b000;
            cnt_d   = CNT_W'(0);
            state_d = S_VAZIO;
        end else begin
            case (state_q)
                S_VAZIO, S_UM, S_RESULTADO: begin
                    if (p_executar) begin
                        rej_d = 1'b1;
                    end else if (p_numero) begin
                        push_d  = 1'b1;
                        state_d = (state_q == S_VAZIO) ? S_UM : S_DOIS;
                    end
                end
                S_DOIS: begin
                    if (p_executar) begin
                        op_d    = bus.chave_operacao;
                        cnt_d   = CNT_W'(ULA_LATENCIA);
                        state_d = S_ESPERA;
                    end else if (p_numero) begin
                        rej_d = 1'b1;
                    end
                end
                S_ESPERA: begin
                    rej_d = p_executar | p_numero;
                    if (cnt_q == CNT_W'(0)) begin
                        exec_d  = 1'b1;
                        state_d = S_EXEC;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_EXEC: begin
                    rej_d   = p_executar | p_numero;
                    state_d = S_CHECA;
                end
                S_CHECA: begin
                    rej_d   = p_executar | p_numero;
                    state_d = bus.erro_ula ? S_ERRO : S_RESULTADO;
                end
                S_ERRO: begin
                    rej_d = p_executar | p_numero;
                end
                default: state_d = S_VAZIO;
            endcase
        end

        case (state_d)
            S_VAZIO:           n_elem_d = 2'd0;
            S_UM, S_RESULTADO: n_elem_d = 2'd1;
            default:           n_elem_d = 2'd2;
        endcase
        ocupado_d = (state_d == S_ESPERA) || (state_d == S_EXEC) || (state_d == S_CHECA);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            hist_q    <= '0;
            press_q   <= '0;
            fill_q    <= 2'd0;
            state_q   <= S_VAZIO;
            cnt_q     <= '0;
            op_q      <= 3'b000;
            push_q    <= 1'b0;
            exec_q    <= 1'b0;
            clr_q     <= 1'b0;
            rej_q     <= 1'b0;
            n_elem_q  <= 2'd0;
            ocupado_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            hist_q    <= hist_d;
            press_q   <= press_d;
            fill_q    <= fill_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            push_q    <= push_d;
            exec_q    <= exec_d;
            clr_q     <= clr_d;
            rej_q     <= rej_d;
            n_elem_q  <= n_elem_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign bus.entrada_numero = push_q;
    assign bus.executar       = exec_q;
    assign bus.limpar_pilha   = clr_q;
    assign bus.operacao_out   = op_q;
    assign bus.n_elem         = n_elem_q;
    assign bus.estado         = state_q;
    assign bus.ocupado        = ocupado_q;
    assign bus.rejeitado      = rej_q;
endmodule

// File: tb/tb_controlador_rpn.sv
// Bench for controlador_rpn: two instances (ULA_LATENCIA 2 and 7) share the same
// button stimulus; a cycle model of the command rules is compared every cycle,
// plus hand-computed checks at the points the directed sequence lands on.
module tb_controlador_rpn;
    localparam int unsigned LAT_A = 2;
    localparam int unsigned LAT_B = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_n = 1'b0, btn_x = 1'b0, btn_l = 1'b0;
    logic [2:0] chave = 3'b000;
    logic       erro = 1'b0;

    int total = 0;
    int bad   = 0;

    controlador_rpn_if if_a ();
    controlador_rpn_if if_b ();

    assign if_a.btn_numero = btn_n;  assign if_b.btn_numero = btn_n;
    assign if_a.btn_executar = btn_x; assign if_b.btn_executar = btn_x;
    assign if_a.btn_limpar = btn_l;  assign if_b.btn_limpar = btn_l;
    assign if_a.chave_operacao = chave; assign if_b.chave_operacao = chave;
    assign if_a.erro_ula = erro;     assign if_b.erro_ula = erro;

    controlador_rpn #(.ULA_LATENCIA(LAT_A)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    controlador_rpn #(.ULA_LATENCIA(LAT_B)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int       t_m;
    bit [3:0] sh_n, sh_x, sh_l;      // [0] newest raw sample, [3] four edges back
    bit       mp_n, mp_x, mp_l;
    int       occ [2];
    int       wait_left [2];         // cycles until the execute pulse, -1 when idle
    bit       in_exec [2], in_chk [2], in_err [2], in_res [2];
    bit [2:0] op_m [2];
    bit       e_push [2], e_exec [2], e_clr [2], e_rej [2];

    function automatic int lat_of(input int i);
        return (i == 0) ? int'(LAT_A) : int'(LAT_B);
    endfunction

    function automatic int exp_estado(input int i);
        if (wait_left[i] >= 0) return 3;
        if (in_exec[i])        return 4;
        if (in_chk[i])         return 5;
        if (in_err[i])         return 7;
        if (in_res[i])         return 6;
        return occ[i];
    endfunction

    task automatic model_reset(input int i);
        occ[i] = 0; wait_left[i] = -1; op_m[i] = 3'b000;
        in_exec[i] = 0; in_chk[i] = 0; in_err[i] = 0; in_res[i] = 0;
        e_push[i] = 0; e_exec[i] = 0; e_clr[i] = 0; e_rej[i] = 0;
    endtask

    task automatic model_step(input int i, input bit pn, input bit px, input bit pl);
        e_push[i] = 0; e_exec[i] = 0; e_clr[i] = 0; e_rej[i] = 0;
        if (pl) begin
            model_reset(i);
            e_clr[i] = 1;
        end else if (wait_left[i] >= 0) begin
            e_rej[i] = pn | px;
            if (wait_left[i] == 0) begin
                wait_left[i] = -1; in_exec[i] = 1; e_exec[i] = 1;
            end else begin
                wait_left[i]--;
            end
        end else if (in_exec[i]) begin
            e_rej[i] = pn | px; in_exec[i] = 0; in_chk[i] = 1;
        end else if (in_chk[i]) begin
            e_rej[i] = pn | px; in_chk[i] = 0;
            if (erro) in_err[i] = 1;
            else begin occ[i] = 1; in_res[i] = 1; end
        end else if (in_err[i]) begin
            e_rej[i] = pn | px;
        end else if (px) begin
            if (occ[i] == 2) begin op_m[i] = chave; wait_left[i] = lat_of(i); end
            else e_rej[i] = 1;
        end else if (pn) begin
            if (occ[i] < 2) begin occ[i]++; e_push[i] = 1; in_res[i] = 0; end
            else e_rej[i] = 1;
        end
    endtask

    // A press acts at edge t when the raw level rose between the samples of
    // edges t-4 and t-3, both taken after reset was released.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_m = 0; sh_n = '0; sh_x = '0; sh_l = '0;
            model_reset(0); model_reset(1);
        end else begin
            t_m  = t_m + 1;
            mp_n = (t_m >= 5) && sh_n[2] && !sh_n[3];
            mp_x = (t_m >= 5) && sh_x[2] && !sh_x[3];
            mp_l = (t_m >= 5) && sh_l[2] && !sh_l[3];
            sh_n = {sh_n[2:0], btn_n};
            sh_x = {sh_x[2:0], btn_x};
            sh_l = {sh_l[2:0], btn_l};
            model_step(0, mp_n, mp_x, mp_l);
            model_step(1, mp_n, mp_x, mp_l);
        end
    end

    // ---------------- checking ----------------
    task automatic cmp(input string nm, input int d, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t got=%0d want=%0d", nm, d, $time, act, exp);
        end
    endtask

    task automatic cmp_dut(input int i, input logic en, input logic ex, input logic cl,
                           input logic [2:0] op, input logic [1:0] ne, input logic [2:0] es,
                           input logic oc, input logic rj);
        cmp("entrada_numero", i, int'(en), int'(e_push[i]));
        cmp("executar",       i, int'(ex), int'(e_exec[i]));
        cmp("limpar_pilha",   i, int'(cl), int'(e_clr[i]));
        cmp("rejeitado",      i, int'(rj), int'(e_rej[i]));
        cmp("operacao_out",   i, int'(op), int'(op_m[i]));
        cmp("n_elem",         i, int'(ne), occ[i]);
        cmp("estado",         i, int'(es), exp_estado(i));
        cmp("ocupado",        i, int'(oc), int'((wait_left[i] >= 0) || in_exec[i] || in_chk[i]));
    endtask

    always @(negedge clk) begin
        cmp_dut(0, if_a.entrada_numero, if_a.executar, if_a.limpar_pilha, if_a.operacao_out,
                if_a.n_elem, if_a.estado, if_a.ocupado, if_a.rejeitado);
        cmp_dut(1, if_b.entrada_numero, if_b.executar, if_b.limpar_pilha, if_b.operacao_out,
                if_b.n_elem, if_b.estado, if_b.ocupado, if_b.rejeitado);
    end

    int push_cnt_a = 0, exec_cnt_a = 0, exec_cnt_b = 0;
    always @(posedge clk) begin
        #1;
        if (if_a.entrada_numero) push_cnt_a++;
        if (if_a.executar)       exec_cnt_a++;
        if (if_b.executar)       exec_cnt_b++;
    end

    // ---------------- directed stimulus ----------------
    task automatic lit(input string nm, input int act, input int exp);
        cmp(nm, 9, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive buttons at a falling edge; after 4 falling edges the command output is visible.
    task automatic press(input bit n, input bit x, input bit l);
        btn_n = n; btn_x = x; btn_l = l;
        tick(4);
    endtask

    task automatic rel();
        btn_n = 0; btn_x = 0; btn_l = 0;
        tick(2);
    endtask

    int base_a, base_b, base_p;

    initial begin
        rst = 1'b1;
        #2 rst = 1'b0;
        tick(2);
        lit("reset_estado", int'(if_a.estado), 0);
        lit("reset_n_elem", int'(if_a.n_elem), 0);
        lit("reset_op", int'(if_a.operacao_out), 0);
        lit("reset_estado_b", int'(if_b.estado), 0);
        rst = 1'b1;
        tick(6);

        press(0, 1, 0); lit("rej_vazio", int'(if_a.rejeitado), 1);
        lit("no_exec_vazio", int'(if_a.executar), 0); rel();
        press(1, 0, 0); lit("push1", int'(if_a.entrada_numero), 1);
        lit("n_elem1", int'(if_a.n_elem), 1); lit("estado_um", int'(if_a.estado), 1); rel();
        press(0, 1, 0); lit("rej_um", int'(if_a.rejeitado), 1);
        lit("estado_um2", int'(if_a.estado), 1); rel();
        press(1, 0, 0); lit("push2", int'(if_a.entrada_numero), 1);
        lit("n_elem2", int'(if_a.n_elem), 2); rel();
        press(1, 0, 0); lit("rej_full", int'(if_a.rejeitado), 1);
        lit("no_push_full", int'(if_a.entrada_numero), 0);
        lit("n_elem_full", int'(if_a.n_elem), 2); rel();

        // numero and executar together in DOIS: execute only
        chave = 3'b010;
        press(1, 1, 0);
        lit("op_latched", int'(if_a.operacao_out), 2);
        lit("estado_espera", int'(if_a.estado), 3);
        lit("sim_no_rej", int'(if_a.rejeitado), 0);
        lit("sim_no_push", int'(if_a.entrada_numero), 0);
        lit("ocupado", int'(if_a.ocupado), 1);
        lit("op_latched_b", int'(if_b.operacao_out), 2);
        btn_n = 0; btn_x = 0;
        tick(2); lit("exec_not_yet", int'(if_a.executar), 0);
        tick(1); lit("exec_at_lat_plus1", int'(if_a.executar), 1);
        lit("estado_exec", int'(if_a.estado), 4);
        chave = 3'b111;
        tick(2); lit("estado_result", int'(if_a.estado), 6);
        lit("n_elem_result", int'(if_a.n_elem), 1);
        lit("op_stable", int'(if_a.operacao_out), 2);
        tick(6); lit("estado_result_b", int'(if_b.estado), 6);
        lit("exec_once_b", exec_cnt_b, 1);
        lit("op_stable_b", int'(if_b.operacao_out), 2);

        // error path
        erro = 1'b1;
        press(1, 0, 0); lit("push_after_res", int'(if_a.entrada_numero), 1);
        lit("n_elem_dois", int'(if_a.n_elem), 2); rel();
        chave = 3'b101;
        press(0, 1, 0); lit("op_101", int'(if_a.operacao_out), 5); rel();
        tick(10);
        lit("estado_erro", int'(if_a.estado), 7);
        lit("estado_erro_b", int'(if_b.estado), 7);
        lit("n_elem_erro", int'(if_a.n_elem), 2);
        press(1, 0, 0); lit("rej_erro_num", int'(if_a.rejeitado), 1); rel();
        press(0, 1, 0); lit("rej_erro_exec", int'(if_a.rejeitado), 1);
        lit("estado_erro2", int'(if_a.estado), 7); rel();
        erro = 1'b0;
        press(0, 0, 1); lit("clr_pulse", int'(if_a.limpar_pilha), 1);
        lit("clr_estado", int'(if_a.estado), 0); lit("clr_op", int'(if_a.operacao_out), 0);
        lit("clr_pulse_b", int'(if_b.limpar_pilha), 1); lit("clr_n_b", int'(if_b.n_elem), 0); rel();

        // abort during the long wait of the latency-7 instance
        press(1, 0, 0); rel(); press(1, 0, 0); rel();
        lit("abort_n_b", int'(if_b.n_elem), 2);
        base_b = exec_cnt_b;
        press(0, 1, 0); lit("abort_espera_b", int'(if_b.estado), 3);
        lit("abort_op_b", int'(if_b.operacao_out), 5);
        btn_x = 0; btn_l = 1;
        tick(4); lit("abort_clr_b", int'(if_b.limpar_pilha), 1);
        lit("abort_estado_b", int'(if_b.estado), 0); lit("abort_op0_b", int'(if_b.operacao_out), 0);
        rel(); tick(10);
        lit("abort_no_exec_b", exec_cnt_b, base_b);
        lit("abort_idle_b", int'(if_b.estado), 0);

        // limpar together with numero, then with executar
        press(1, 0, 1); lit("ln_clr", int'(if_a.limpar_pilha), 1);
        lit("ln_no_push", int'(if_a.entrada_numero), 0); lit("ln_estado", int'(if_a.estado), 0); rel();
        press(1, 0, 0); rel(); press(1, 0, 0); rel();
        lit("lx_n_elem", int'(if_a.n_elem), 2);
        base_a = exec_cnt_a; base_b = exec_cnt_b;
        press(0, 1, 1); lit("lx_clr", int'(if_a.limpar_pilha), 1);
        lit("lx_estado", int'(if_a.estado), 0); lit("lx_no_rej", int'(if_a.rejeitado), 0); rel();
        tick(10);
        lit("lx_no_exec_a", exec_cnt_a, base_a);
        lit("lx_no_exec_b", exec_cnt_b, base_b);

        // reset with numero held
        press(1, 0, 0); rel();
        press(1, 0, 0); lit("held_push", int'(if_a.entrada_numero), 1);
        lit("held_n_elem", int'(if_a.n_elem), 2);
        base_p = push_cnt_a;
        #2 rst = 1'b0;
        #1;
        lit("rst_async_estado", int'(if_a.estado), 0);
        lit("rst_async_n_elem", int'(if_a.n_elem), 0);
        lit("rst_async_push", int'(if_a.entrada_numero), 0);
        lit("rst_async_estado_b", int'(if_b.estado), 0);
        tick(2);
        rst = 1'b1;
        tick(8);
        lit("held_no_push", push_cnt_a, base_p);
        lit("held_estado", int'(if_a.estado), 0);
        rel();
        press(1, 0, 0); lit("repress_push", int'(if_a.entrada_numero), 1);
        lit("repress_n_elem", int'(if_a.n_elem), 1); rel();

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog");
    end
endmodule
